// File: rtl/gmac_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gmac_tx_arbiter : NUM_CH framed sources arbitrated onto the GMAC TX stream |
// | Optional GMAC_ARB_STATS_EN adds frame_cnt / abort_cnt. Rev 1.0             |
// +----------------------------------------------------------------------------+
module gmac_tx_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int ARB_MODE    = 0,
  parameter int SOF_TIMEOUT = 1024,
  parameter int MAX_FRAME   = 1472,
  parameter int IFG_CYCLES  = 12
) (
  input  logic                     clk125,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_val,
  input  logic [NUM_CH-1:0]        ch_sof,
  input  logic [NUM_CH-1:0]        ch_eof,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_confirm,
  output logic                     mac_req,
  input  logic                     mac_confirm,
  output logic                     mac_val,
  output logic                     mac_sof,
  output logic                     mac_eof,
  output logic [DATA_W-1:0]        mac_data,
  output logic [2:0]               active_ch,
  output logic                     busy,
  output logic                     abort_err
`ifdef GMAC_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]     frame_cnt,
  output logic [NUM_CH*16-1:0]     abort_cnt
`endif
);

  localparam int          c_CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] c_TO_LAST  = 16'(SOF_TIMEOUT - 1);
  localparam logic [15:0] c_MAX      = 16'(MAX_FRAME);
  localparam logic [7:0]  c_IFG_LAST = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC_REQ, S_WAIT_SOF, S_STREAM, S_DRAIN, S_GAP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cur, r_last, w_win, w_idx;
  logic [15:0]       r_timer, r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]        r_gap;
  logic [DATA_W-1:0] w_bytes [NUM_CH];
  logic              w_req, w_val, w_sof, w_eof;
  logic              w_start, w_grant, w_fwd, w_fwd_sof, w_fwd_eof, w_abort;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_bytes
    assign w_bytes[g] = ch_data[g*DATA_W +: DATA_W];
  end

  assign w_req     = ch_req[r_cur];
  assign w_val     = ch_val[r_cur];
  assign w_sof     = ch_sof[r_cur];
  assign w_eof     = ch_eof[r_cur];
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign mac_req   = (r_state == S_MAC_REQ);
  assign busy      = (r_state != S_IDLE);

  // Descending scan: the candidate closest to the start point is written last and wins.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (ARB_MODE == 0) w_idx = c_CW'((int'(r_last) + k) % NUM_CH);
      else               w_idx = c_CW'(k - 1);
      if (ch_req[w_idx]) w_win = w_idx;
    end
  end

  always_ff @(posedge clk125) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_grant     = 1'b0;
    w_fwd       = 1'b0;
    w_fwd_sof   = 1'b0;
    w_fwd_eof   = 1'b0;
    w_abort     = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|ch_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_MAC_REQ;
        end
      end
      S_MAC_REQ: begin
        if (mac_confirm) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WAIT_SOF;
        end else if (!w_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_SOF: begin
        if (w_val && w_sof) begin
          w_fwd     = 1'b1;
          w_fwd_sof = 1'b1;
          w_cnt_nxt = 16'd1;
          if (w_eof) begin
            w_fwd_eof   = 1'b1;
            w_state_nxt = S_GAP;
          end else if (c_MAX == 16'd1) begin
            w_fwd_eof   = 1'b1;
            w_abort     = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end else if (r_timer == c_TO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (w_val) begin
          w_fwd     = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_eof) begin
            w_fwd_eof   = 1'b1;
            w_state_nxt = S_GAP;
          end else if (w_cnt_inc == c_MAX) begin
            w_fwd_eof   = 1'b1;
            w_abort     = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_val && w_eof) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_gap == c_IFG_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_last     <= c_CW'(NUM_CH - 1);
      r_timer    <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      ch_confirm <= '0;
      mac_val    <= 1'b0;
      mac_sof    <= 1'b0;
      mac_eof    <= 1'b0;
      mac_data   <= '0;
      active_ch  <= '0;
      abort_err  <= 1'b0;
    end else begin
      ch_confirm <= '0;
      abort_err  <= w_abort;
      mac_val    <= w_fwd;
      mac_sof    <= w_fwd_sof;
      mac_eof    <= w_fwd_eof;
      r_cnt      <= w_cnt_nxt;
      r_timer    <= (r_state == S_WAIT_SOF) ? r_timer + 16'd1 : 16'd0;
      r_gap      <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
      if (w_fwd)   mac_data <= w_bytes[r_cur];
      if (w_start) r_cur    <= w_win;
      if (w_grant) begin
        ch_confirm[r_cur] <= 1'b1;
        r_last            <= r_cur;
        active_ch         <= 3'(r_cur);
      end
    end
  end

`ifdef GMAC_ARB_STATS_EN
  // r_cur stays on the aborting/ending channel for the cycle the pulse is visible.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    logic [31:0] r_frames;
    logic [15:0] r_aborts;
    always_ff @(posedge clk125) begin
      if (!rst_n) begin
        r_frames <= '0;
        r_aborts <= '0;
      end else if (r_cur == c_CW'(g)) begin
        if (mac_eof)   r_frames <= r_frames + 32'd1;
        if (abort_err) r_aborts <= r_aborts + 16'd1;
      end
    end
    assign frame_cnt[g*32 +: 32] = r_frames;
    assign abort_cnt[g*16 +: 16] = r_aborts;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gmac_tx_arbiter.sv
`default_nettype none
// tb_gmac_tx_arbiter : scoreboard bench, u_dut0 round-robin (timeout 16), u_dut1 fixed priority (max frame 8)
module tb_gmac_tx_arbiter;
  logic clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  logic        rst_n;
  logic [3:0]  ch_req0, ch_req1, ch_val, ch_sof, ch_eof;
  logic [31:0] ch_data;
  logic        mac_confirm0, mac_confirm1;
  logic [3:0]  ch_confirm0, ch_confirm1;
  logic        mac_req0, mac_val0, mac_sof0, mac_eof0, busy0, abort_err0;
  logic        mac_req1, mac_val1, mac_sof1, mac_eof1, busy1, abort_err1;
  logic [7:0]  mac_data0, mac_data1;
  logic [2:0]  active_ch0, active_ch1;

  gmac_tx_arbiter #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(0), .SOF_TIMEOUT(16),
                    .MAX_FRAME(64), .IFG_CYCLES(12)) u_dut0 (
    .clk125(clk125), .rst_n(rst_n), .ch_req(ch_req0), .ch_val(ch_val), .ch_sof(ch_sof),
    .ch_eof(ch_eof), .ch_data(ch_data), .ch_confirm(ch_confirm0), .mac_req(mac_req0),
    .mac_confirm(mac_confirm0), .mac_val(mac_val0), .mac_sof(mac_sof0), .mac_eof(mac_eof0),
    .mac_data(mac_data0), .active_ch(active_ch0), .busy(busy0), .abort_err(abort_err0));

  gmac_tx_arbiter #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(1), .SOF_TIMEOUT(1024),
                    .MAX_FRAME(8), .IFG_CYCLES(3)) u_dut1 (
    .clk125(clk125), .rst_n(rst_n), .ch_req(ch_req1), .ch_val(ch_val), .ch_sof(ch_sof),
    .ch_eof(ch_eof), .ch_data(ch_data), .ch_confirm(ch_confirm1), .mac_req(mac_req1),
    .mac_confirm(mac_confirm1), .mac_val(mac_val1), .mac_sof(mac_sof1), .mac_eof(mac_eof1),
    .mac_data(mac_data1), .active_ch(active_ch1), .busy(busy1), .abort_err(abort_err1));

  int         n_checks = 0;
  int         n_fails  = 0;
  int         ab0 = 0;
  int         ab1 = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int         gq0[$];
  int         gq1[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] out0();
    return 32'({ch_confirm0, mac_req0, mac_val0, mac_sof0, mac_eof0, mac_data0,
                active_ch0, busy0, abort_err0});
  endfunction

  function automatic logic [31:0] out1();
    return 32'({ch_confirm1, mac_req1, mac_val1, mac_sof1, mac_eof1, mac_data1,
                active_ch1, busy1, abort_err1});
  endfunction

  // Monitors: pop expected bytes / grants whenever a DUT presents one.
  always @(negedge clk125) begin : mon0
    logic [31:0] e;
    int          w;
    if (mac_val0) begin
      e = 32'hDEADBEEF;
      if (q0.size() > 0) e = 32'(q0.pop_front());
      check("dut0_byte", 32'({mac_data0, mac_sof0, mac_eof0}), e);
    end
    if (ch_confirm0 != 4'd0) begin
      w = 99;
      if (gq0.size() > 0) w = gq0.pop_front();
      check("dut0_grant", 32'({ch_confirm0, active_ch0}), 32'({4'(32'd1 << w), 3'(w)}));
    end
    if (abort_err0) ab0++;
  end

  always @(negedge clk125) begin : mon1
    logic [31:0] e;
    int          w;
    if (mac_val1) begin
      e = 32'hDEADBEEF;
      if (q1.size() > 0) e = 32'(q1.pop_front());
      check("dut1_byte", 32'({mac_data1, mac_sof1, mac_eof1}), e);
    end
    if (ch_confirm1 != 4'd0) begin
      w = 99;
      if (gq1.size() > 0) w = gq1.pop_front();
      check("dut1_grant", 32'({ch_confirm1, active_ch1}), 32'({4'(32'd1 << w), 3'(w)}));
    end
    if (abort_err1) ab1++;
  end

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic do_grant(input int d, input int dly);
    int n;
    n = 0;
    while (((d == 0) ? mac_req0 : mac_req1) == 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check((d == 0) ? "dut0_req_wait" : "dut1_req_wait", 32'(n < 100), 32'd1);
    repeat (dly) tick();
    if (d == 0) mac_confirm0 = 1'b1;
    else        mac_confirm1 = 1'b1;
    tick();
    mac_confirm0 = 1'b0;
    mac_confirm1 = 1'b0;
  endtask

  // Drives n bytes on channel ch; only the first maxb are expected out, the last one with eof.
  task automatic send_frame(input int d, input int ch, input int n, input logic [7:0] base,
                            input int maxb, input bit eof_en);
    logic [7:0] b;
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      if (i < maxb) begin
        e = {b, (i == 0), ((eof_en && i == n - 1) || i == maxb - 1)};
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      ch_val  = 4'(32'd1 << ch);
      ch_sof  = (i == 0) ? ch_val : 4'd0;
      ch_eof  = (eof_en && i == n - 1) ? ch_val : 4'd0;
      ch_data = 32'(b) << (8 * ch);
      tick();
    end
    ch_val  = '0;
    ch_sof  = '0;
    ch_eof  = '0;
    ch_data = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int rr_ord[5];
    int fp_len[3];
    rr_ord = '{1, 2, 3, 0, 1};
    fp_len = '{4, 8, 2};
    rst_n = 1'b0; ch_req0 = '0; ch_req1 = '0; ch_val = '0; ch_sof = '0; ch_eof = '0;
    ch_data = '0; mac_confirm0 = 1'b0; mac_confirm1 = 1'b0;
    repeat (3) tick();
    check("reset_dut0", out0(), 32'd0);
    check("reset_dut1", out1(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single channel 64-byte frame, IFG, then withdraw of channel 1.
    ch_req0 = 4'b0001;
    gq0.push_back(0);
    do_grant(0, 3);
    send_frame(0, 0, 64, 8'h00, 64, 1'b1);
    ch_req0 = 4'b0010;
    n = 0;
    while (!mac_req0 && n < 50) begin tick(); n++; end
    check("ifg_to_next_req", 32'(n), 32'd13);
    ch_req0 = 4'b0000;
    tick();
    check("withdraw_ch1", 32'({mac_req0, busy0}), 32'd0);
    repeat (3) tick();

    // Round-robin with all channels requesting; last winner was channel 0.
    ch_req0 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gq0.push_back(rr_ord[k]);
      do_grant(0, 1);
      send_frame(0, rr_ord[k], 10, 8'h40 + 8'(k * 16), 64, 1'b1);
    end
    ch_req0 = 4'b0100;

    // SoF timeout on channel 2 with stray bytes on granted and non-granted channels.
    gq0.push_back(2);
    do_grant(0, 1);
    ch_req0 = 4'b0000;
    ch_val  = 4'b0101;
    ch_sof  = 4'b0001;
    ch_data = 32'h00AA_00BB;
    n = 0;
    while (!abort_err0 && n < 40) begin tick(); n++; end
    ch_val = '0; ch_sof = '0; ch_data = '0;
    check("sof_timeout_cycles", 32'(n), 32'd16);
    check("timeout_idle", 32'(busy0), 32'd0);
    tick();
    check("abort_one_cycle", 32'(abort_err0), 32'd0);
    check("abort_count_dut0", 32'(ab0), 32'd1);

    // Fixed priority: channel 1 beats channel 3 every time; 8-byte frame is exactly max.
    ch_req1 = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      gq1.push_back(1);
      do_grant(1, 2);
      send_frame(1, 1, fp_len[k], 8'h90 + 8'(k * 16), 8, 1'b1);
    end
    ch_req1 = 4'b1000;
    tick();
    check("fp_no_abort", 32'(ab1), 32'd0);

    // Oversize 12-byte frame on channel 3 against max 8.
    gq1.push_back(3);
    do_grant(1, 2);
    send_frame(1, 3, 12, 8'hC0, 8, 1'b1);
    n = 0;
    while (!mac_req1 && n < 50) begin tick(); n++; end
    check("drain_then_gap", 32'(n), 32'd4);
    check("oversize_abort", 32'(ab1), 32'd1);
    ch_req1 = 4'b0000;
    tick();
    check("withdraw_dut1", 32'(mac_req1), 32'd0);

    // Reset mid-stream, then channel 0 must win first.
    ch_req0 = 4'b0100;
    gq0.push_back(2);
    do_grant(0, 1);
    send_frame(0, 2, 3, 8'hE0, 64, 1'b0);
    rst_n = 1'b0;
    tick();
    check("reset_mid_stream", out0(), 32'd0);
    rst_n   = 1'b1;
    ch_req0 = 4'b1111;
    gq0.push_back(0);
    do_grant(0, 1);
    send_frame(0, 0, 2, 8'hF0, 64, 1'b1);
    ch_req0 = 4'b0000;
    repeat (20) tick();

    check("dut0_bytes_left", 32'(q0.size()), 32'd0);
    check("dut1_bytes_left", 32'(q1.size()), 32'd0);
    check("dut0_grants_left", 32'(gq0.size()), 32'd0);
    check("dut1_grants_left", 32'(gq1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gmac_tx_arbiter.md
Name: gmac_tx_arbiter

Overview:
Parametrised N-channel transmit arbiter in front of the custom GMAC byte-stream input (Val/SoF/EoF/Req/Data plus confirm handshake). It generalises the single-channel feed to NUM_CH framed sources, with round-robin or fixed-priority arbitration. It adds per-frame SoF timeout, maximum frame length enforcement with forced termination, and a programmable inter-frame gap. It sits in the clk125 domain between the user payload sources and the GMAC TX path.

Parameters:
NUM_CH, 4, number of source channels (2..8)
DATA_W, 8, byte lane width; fixed at 8 for the GMAC
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
SOF_TIMEOUT, 1024, cycles allowed from channel confirm to SoF (1..65535)
MAX_FRAME, 1472, maximum payload bytes per frame (1..65535)
IFG_CYCLES, 12, idle cycles forced after each frame end (0..255)

Ports:
clk125  in  1  system clock, 125 MHz
rst_n  in  1  synchronous reset, active-low
ch_req  in  NUM_CH  per-channel transmit request, level
ch_val  in  NUM_CH  per-channel byte valid
ch_sof  in  NUM_CH  per-channel start of frame, qualified by ch_val
ch_eof  in  NUM_CH  per-channel end of frame, qualified by ch_val
ch_data  in  NUM_CH*8  channel i data at bits [8i+7:8i]
ch_confirm  out  NUM_CH  one-cycle grant pulse to the winning channel
mac_req  out  1  request to GMAC
mac_confirm  in  1  GMAC grant pulse
mac_val  out  1  byte valid to GMAC
mac_sof  out  1  start of frame to GMAC
mac_eof  out  1  end of frame to GMAC
mac_data  out  8  byte to GMAC
active_ch  out  3  index of the currently granted channel
busy  out  1  high in every state except IDLE
abort_err  out  1  one-cycle pulse on timeout or oversize abort

Behaviour:
- Reset (rst_n = 0 at a clk125 edge): all outputs 0; FSM goes to IDLE; RR pointer set to NUM_CH-1 so channel 0 wins first; counters cleared. A reset mid-frame truncates the frame with no mac_eof.
- IDLE: if any ch_req bit is set, select a winner and register it as cur. RR searches from last_winner+1 with wrap; fixed priority takes the lowest set index. Assert mac_req and go to MAC_REQ. Selection is evaluated in the same cycle ch_req is sampled.
- MAC_REQ: hold mac_req high.
  - On mac_confirm: drop mac_req next cycle, pulse ch_confirm[cur] for 1 cycle, update last_winner = cur, clear the timer, go to WAIT_SOF.
  - If ch_req[cur] falls before mac_confirm: drop mac_req and return to IDLE with no grant.
- WAIT_SOF: timer increments each cycle.
  - ch_val[cur] with ch_sof[cur]: forward the byte, set byte_cnt = 1, go to STREAM. If ch_eof[cur] is also set (1-byte frame), go to GAP.
  - ch_val without sof: byte is dropped.
  - Timer reaches SOF_TIMEOUT-1 with no SoF: pulse abort_err, go to IDLE.
- STREAM: each ch_val[cur] byte is forwarded and byte_cnt increments (16 bit, saturating).
  - ch_eof[cur]: go to GAP.
  - The byte that makes byte_cnt == MAX_FRAME without eof is output with mac_eof forced, abort_err pulses, and the FSM goes to DRAIN.
  - A ch_sof inside a frame is ignored.
- DRAIN: discard ch_val[cur] bytes until ch_eof[cur], then go to GAP.
- GAP: count IFG_CYCLES cycles with mac_val = 0, then go to IDLE. With IFG_CYCLES = 0, go to IDLE on the next cycle.
- Forwarding latency: exactly 1 cycle. mac_val, mac_sof, mac_eof and mac_data are registered copies of the cur channel's signals, and mac_val = 0 whenever a byte is not forwarded.
- ch_val, ch_sof and ch_eof of non-granted channels are ignored in all states.
- Simultaneous requests are resolved per the ARB_MODE rule. Under RR, a channel that keeps ch_req high after its frame cannot win twice in a row while another channel is requesting.
- active_ch holds its last value outside a grant. Reset value is 0.

Optional Feature:
GMAC_ARB_STATS_EN
- Defined: adds outputs frame_cnt (NUM_CH*32, out) and abort_cnt (NUM_CH*16, out), cleared by rst_n.
  - frame_cnt[i] increments on each mac_eof for channel i, including forced ones.
  - abort_cnt[i] increments on each abort_err for channel i.
  - Both wrap at maximum.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single channel: ch_req[0] = 1, mac_confirm 3 cycles later, then a 64-byte frame 0x00..0x3F -> ch_confirm[0] pulses once; mac_data reproduces 0x00..0x3F one cycle after input, with mac_sof on 0x00 and mac_eof on 0x3F; then 12 idle cycles before the next mac_req.
- RR fairness, ARB_MODE = 0: ch_req = 4'b1111 held, 10-byte frames -> grant order 0,1,2,3,0; active_ch follows that order.
- Fixed priority, ARB_MODE = 1: ch_req = 4'b1010 held -> channel 1 granted every time; channel 3 never granted.
- SoF timeout, SOF_TIMEOUT = 16: grant channel 2 and send no SoF -> abort_err pulses 16 cycles after ch_confirm; FSM returns to IDLE; mac_val stays 0.
- Oversize, MAX_FRAME = 8: send a 12-byte frame -> 8 bytes out with mac_eof on byte 8; abort_err pulses; bytes 9..12 dropped; GAP entered after the input eof.
- Withdraw and reset: drop ch_req[1] before mac_confirm -> mac_req falls and no ch_confirm is issued; assert rst_n = 0 mid-STREAM -> all outputs 0 next cycle, and the next grant goes to channel 0.
